// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg: shared types and helpers for the UART transmit arbiter | rev 1.0 ====
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int UART_DATA_W = 8;

  // Cycles for one 10-bit frame plus the transmitter's completion cycle.
  function automatic int uart_frame_cycles(input int clk_freq, input int baud_rate);
    return 10 * (clk_freq / baud_rate) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ==== uart_rr_pick: rotating-priority encoder, nearest request after last_grant wins | rev 1.0 ====
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               any_req_o,
  output logic [ID_W-1:0]    grant_id_o
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    any_req_o  = |req_i;
    grant_id_o = last_grant_i;
    w_cand     = '0;
    // Scan farthest-first so the closest set bit after last_grant is the one that sticks.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (req_i[w_cand]) begin
        grant_id_o = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ==== uart_tx_arbiter: round-robin sharing of one UART transmitter with watchdog | rev 1.0 ====
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       uart_start,
  output logic [7:0]                 uart_data,
  input  logic                       uart_done_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state_q;
  logic [ID_W-1:0]        cur_id_q;
  logic [ID_W-1:0]        last_grant_q;
  logic [UART_DATA_W-1:0] data_q;
  logic [CNT_W-1:0]       wd_q;
  logic                   busy_q;
  logic                   err_q;
  logic                   done_pend_q;

  logic                   w_any_req;
  logic [ID_W-1:0]        w_grant_id;
  logic [UART_DATA_W-1:0] w_sel_byte;
  logic [NUM_REQ-1:0]     w_onehot;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .any_req_o    (w_any_req),
    .grant_id_o   (w_grant_id)
  );

  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_byte = req_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      cur_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      data_q       <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      done_pend_q  <= 1'b0;
    end else begin
      done_pend_q <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ARB_IDLE: begin
          if (w_any_req) begin
            cur_id_q <= w_grant_id;
            data_q   <= w_sel_byte;
            busy_q   <= 1'b1;
            state_q  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wd_q    <= '0;
          state_q <= ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          wd_q <= wd_q + CNT_W'(1);
          // A completion in the same cycle as the watchdog expiry is a success.
          if (uart_done_tx) begin
            done_pend_q  <= 1'b1;
            last_grant_q <= cur_id_q;
            busy_q       <= 1'b0;
            state_q      <= ARB_IDLE;
          end else if (wd_q == WD_LAST) begin
            err_q        <= 1'b1;
            last_grant_q <= cur_id_q;
            busy_q       <= 1'b0;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // done_pend_q is only high in the IDLE cycle after completion, while cur_id_q still names the finished requester.
  assign w_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_id_q;
  assign ack         = (state_q == ARB_ISSUE) ? w_onehot : '0;
  assign done        = done_pend_q ? w_onehot : '0;
  assign uart_start  = (state_q == ARB_ISSUE);
  assign uart_data   = data_q;
  assign busy        = busy_q;
  assign cur_id      = cur_id_q;
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter's start / data / done_tx handshake: one byte in flight at a time, with a one-cycle start pulse and data held stable for the whole frame.
- Sits between client logic (command/status sources) and the uart transmit path; uart_start and uart_data drive the transmitter's start and tx_data_in.
- A watchdog recovers the arbiter if done_tx never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 32768, cycles allowed in WAIT_DONE before abort. Must exceed 10*clk_freq/baud_rate + 2.
- CNT_W, $clog2(TIMEOUT_CYCLES), watchdog counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request; hold high until ack
- req_data  in  NUM_REQ*8  byte for requester i at [8*i+7:8*i]; stable while req[i] is high
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i issued to transmitter
- done  out  NUM_REQ  one-cycle pulse: byte of requester i fully sent
- uart_start  out  1  one-cycle start pulse to transmitter
- uart_data  out  8  byte to transmitter; registered, stable from ISSUE through WAIT_DONE
- uart_done_tx  in  1  transmitter frame-complete pulse
- busy  out  1  high in ISSUE and WAIT_DONE
- cur_id  out  $clog2(NUM_REQ)  index of current grant; valid while busy
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset values:
  - Outputs: ack=0, done=0, uart_start=0, uart_data=0, busy=0, cur_id=0, timeout_err=0.
  - Internal: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins the first arbitration), watchdog=0.
  - Reset mid-frame aborts silently; no done pulse. The transmitter shares rst.
- States: IDLE, ISSUE, WAIT_DONE. Encoding comes from the package enum.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch cur_id and uart_data <= req_data[cur_id], then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - uart_start=1 and ack[cur_id]=1; clear watchdog; go to WAIT_DONE.
  - Latency: req sampled in IDLE at cycle t gives uart_start/ack at t+1.
- WAIT_DONE:
  - uart_start=0; watchdog increments each cycle.
  - On uart_done_tx=1: done[cur_id]=1, last_grant<=cur_id, go to IDLE.
  - Else, if watchdog==TIMEOUT_CYCLES-1: timeout_err<=1, last_grant<=cur_id, go to IDLE, no done pulse.
  - If uart_done_tx and the timeout coincide, done wins and no error is set.
- The mandatory IDLE cycle after each frame guarantees the transmitter has returned to its idle state before the next start.
- uart_done_tx seen in IDLE or ISSUE is ignored (spurious).
- A req that is still high after done is a new request and competes normally; there is no starvation, because the grant rotates.
- Only one ack and one done bit is ever high at a time.
- Removing req before ack is a protocol violation; the arbiter still sends the byte it latched.
- err_clr and a timeout in the same cycle: set wins.
- All outputs are registered except ack, done and uart_start. Those three decode from the state register and cur_id only, never from inputs.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DONE}
  - localparam UART_DATA_W=8
  - function uart_frame_cycles(clk_freq, baud_rate) = 10*(clk_freq/baud_rate)+1, for the bench and for TIMEOUT checks
- One sub-module, uart_rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: any_req, grant_id.

Test Plan:
- Single request: transmitter with clk_freq=1_000_000, baud_rate=100_000 (divide 10); req[2]=1, data 0xA5 -> ack[2] and uart_start one cycle later; tx line shows 0, 1,0,1,0,0,1,0,1, 1; done[2] pulses exactly once.
- All four req high after reset, data 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3, bytes on tx in that order, one IDLE cycle between done and the next start.
- req[1] and req[3] held high for 6 frames -> grants alternate 1,3,1,3,1,3; requester 3 is never skipped.
- uart_done_tx tied 0, TIMEOUT_CYCLES=50 -> timeout_err rises 50 cycles after ISSUE with no done pulse; next arbitration proceeds; err_clr drops the flag next cycle.
- rst asserted 30 cycles into a frame -> next cycle: all outputs 0, state IDLE; with req[0] pending after release, ack[0] arrives 2 cycles after rst falls.
- uart_done_tx pulsed while idle with no req -> no done, no state change.
